// File: rtl/collect_data_121_if.sv
// Bundles the router-slot inputs, the operator controls and the collected-entry
// outputs of collect_data_121. The design uses the slave modport and the driver uses master.
interface collect_data_121_if #(
  parameter int N_ROUTERS = 121,
  parameter int PKT_W     = 15
);
  localparam int IDX_W = $clog2(N_ROUTERS);

  logic [N_ROUTERS*PKT_W-1:0] in_routers;
  logic                       sw_clear;
  logic                       key_next;
  logic                       rx_valid;
  logic [IDX_W-1:0]           rx_router;
  logic [PKT_W-2:0]           rx_data;
  logic [7:0]                 rx_count;
  logic [15:0]                rx_stamp;
  logic [6:0]                 hex_router;
  logic [6:0]                 hex_data;

  modport master (
    output in_routers, sw_clear, key_next,
    input  rx_valid, rx_router, rx_data, rx_count, rx_stamp, hex_router, hex_data
  );

  modport slave (
    input  in_routers, sw_clear, key_next,
    output rx_valid, rx_router, rx_data, rx_count, rx_stamp, hex_router, hex_data
  );
endinterface

// File: rtl/collect_data_121.sv
// Collects new-packet arrivals from the router local outputs into a small FIFO for display.
// Optional macro ARRIVAL_STAMP_EN adds a 16-bit cycle stamp stored with each FIFO entry.
module collect_data_121 #(
  parameter int N_ROUTERS  = 121,
  parameter int PKT_W      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  collect_data_121_if.slave    bus
);
  localparam int IDX_W = $clog2(N_ROUTERS);
  localparam int DAT_W = PKT_W - 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] DASH = 7'b0111111;

  logic [N_ROUTERS-1:0] cur_v;
  logic [N_ROUTERS-1:0] arrival;
  logic [N_ROUTERS-1:0] prev_v_reg;
  logic [N_ROUTERS-1:0] pending_reg;
  logic [N_ROUTERS-1:0] pending_next;
  logic [N_ROUTERS-1:0] service_mask;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [DAT_W-1:0] sel_payload;
  logic             sel_valid;
  logic             service;
  logic             push;
  logic             pop;
  logic             key_rise;
  logic             key_reg;

  logic [IDX_W-1:0] mem_router [FIFO_DEPTH];
  logic [DAT_W-1:0] mem_data   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] fifo_cnt_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic [IDX_W-1:0] head_router;
  logic [DAT_W-1:0] head_data;

  logic [7:0] rx_count_reg;
  logic [6:0] hex_router_reg;
  logic [6:0] hex_data_reg;

`ifdef ARRIVAL_STAMP_EN
  logic [15:0] stamp_reg;
  logic [15:0] mem_stamp [FIFO_DEPTH];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_ROUTERS; gi++) begin : g_slot
      assign cur_v[gi]   = bus.in_routers[gi*PKT_W + PKT_W - 1];
      assign arrival[gi] = cur_v[gi] & ~prev_v_reg[gi];
    end
  endgenerate

  // Descending scan so the lowest pending index is the last one to win.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = N_ROUTERS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign fifo_empty  = (fifo_cnt_reg == '0);
  assign fifo_full   = (fifo_cnt_reg == CNT_W'(FIFO_DEPTH));
  assign sel_valid   = cur_v[sel_idx];
  assign sel_payload = bus.in_routers[32'(sel_idx)*PKT_W +: DAT_W];
  assign service     = sel_found & ~fifo_full;
  assign push        = service & sel_valid;
  assign key_rise    = bus.key_next & ~key_reg;
  assign pop         = key_rise & ~fifo_empty;

  // An arrival landing on the slot being serviced merges into that service.
  assign service_mask = service ? (N_ROUTERS'(1) << sel_idx) : '0;
  assign pending_next = (pending_reg | arrival) & ~service_mask;

  assign head_router = mem_router[rd_ptr_reg];
  assign head_data   = mem_data[rd_ptr_reg];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem_router[wr_ptr_reg] <= sel_idx;
      mem_data[wr_ptr_reg]   <= sel_payload;
`ifdef ARRIVAL_STAMP_EN
      // The arrival was detected one edge before the earliest possible push.
      mem_stamp[wr_ptr_reg]  <= stamp_reg - 16'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_v_reg     <= '0;
      pending_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_cnt_reg   <= '0;
      rx_count_reg   <= '0;
      key_reg        <= 1'b0;
      hex_router_reg <= DASH;
      hex_data_reg   <= DASH;
    end else begin
      prev_v_reg     <= cur_v;
      key_reg        <= bus.key_next;
      hex_router_reg <= fifo_empty ? DASH : seg7(head_router[3:0]);
      hex_data_reg   <= fifo_empty ? DASH : seg7(head_data[3:0]);
      if (bus.sw_clear) begin
        pending_reg  <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        fifo_cnt_reg <= '0;
        rx_count_reg <= '0;
      end else begin
        pending_reg <= pending_next;
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (rx_count_reg != 8'hFF) rx_count_reg <= rx_count_reg + 8'd1;
        end
        if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push, pop})
          2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
          2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
          default: fifo_cnt_reg <= fifo_cnt_reg;
        endcase
      end
    end
  end

`ifdef ARRIVAL_STAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) stamp_reg <= '0;
    else        stamp_reg <= stamp_reg + 16'd1;
  end
  assign bus.rx_stamp = fifo_empty ? 16'd0 : mem_stamp[rd_ptr_reg];
`else
  assign bus.rx_stamp = 16'd0;
`endif

  assign bus.rx_valid   = ~fifo_empty;
  assign bus.rx_router  = fifo_empty ? '0 : head_router;
  assign bus.rx_data    = fifo_empty ? '0 : head_data;
  assign bus.rx_count   = rx_count_reg;
  assign bus.hex_router = hex_router_reg;
  assign bus.hex_data   = hex_data_reg;
endmodule

// File: tb/tb_collect_data_121.sv
// Randomized and directed bench for collect_data_121 against a queue-based arrival model.
module tb_collect_data_121;
  localparam int N = 121;
  localparam int W = 15;
  localparam int D = 4;
  localparam logic [6:0] DASH = 7'b0111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  collect_data_121_if #(.N_ROUTERS(N), .PKT_W(W)) bus();
  collect_data_121 #(.N_ROUTERS(N), .PKT_W(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Stimulus state
  bit        v_in [N];
  bit [13:0] p_in [N];
  bit        clr;
  bit        key;

  // Reference model state
  bit   m_prev [N];
  bit   m_pend [N];
  int   m_qr[$];
  int   m_qd[$];
  int   m_qs[$];
  int   m_count;
  bit   m_key;
  int   m_cyc;
  logic [6:0] m_hex_r;
  logic [6:0] m_hex_d;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) bus.in_routers[i*W +: W] = {v_in[i], p_in[i]};
    bus.sw_clear = clr;
    bus.key_next = key;
  endtask

  task automatic model_edge();
    int old_size;
    int k;
    if (!rst_n) begin
      foreach (m_prev[i]) begin m_prev[i] = 0; m_pend[i] = 0; end
      m_qr.delete(); m_qd.delete(); m_qs.delete();
      m_count = 0; m_key = 0; m_cyc = 0;
      m_hex_r = DASH; m_hex_d = DASH;
      return;
    end
    m_hex_r = (m_qr.size() > 0) ? seg_tab[m_qr[0] % 16] : DASH;
    m_hex_d = (m_qd.size() > 0) ? seg_tab[m_qd[0] % 16] : DASH;
    if (clr) begin
      m_qr.delete(); m_qd.delete(); m_qs.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_count = 0;
    end else begin
      old_size = m_qr.size();
      k = -1;
      if (old_size < D)
        for (int i = 0; i < N; i++) if (m_pend[i] && k < 0) k = i;
      for (int i = 0; i < N; i++) if (v_in[i] && !m_prev[i]) m_pend[i] = 1;
      if (key && !m_key && old_size > 0) begin
        $display("pop  router=%0d data=%04h", m_qr[0], m_qd[0]);
        void'(m_qr.pop_front()); void'(m_qd.pop_front()); void'(m_qs.pop_front());
      end
      if (k >= 0) begin
        m_pend[k] = 0;
        if (v_in[k]) begin
          m_qr.push_back(k);
          m_qd.push_back(int'(p_in[k]));
          m_qs.push_back((m_cyc - 1) & 16'hFFFF);
          if (m_count < 255) m_count++;
        end
      end
    end
    foreach (m_prev[i]) m_prev[i] = v_in[i];
    m_key = key;
    m_cyc = (m_cyc + 1) & 16'hFFFF;
  endtask

  task automatic compare();
    bit ne;
    ne = (m_qr.size() > 0);
    check("rx_valid", 32'(bus.rx_valid), 32'(ne));
    check("rx_router", 32'(bus.rx_router), ne ? m_qr[0] : 0);
    check("rx_data", 32'(bus.rx_data), ne ? m_qd[0] : 0);
    check("rx_count", 32'(bus.rx_count), m_count);
`ifdef ARRIVAL_STAMP_EN
    check("rx_stamp", 32'(bus.rx_stamp), ne ? m_qs[0] : 0);
`else
    check("rx_stamp", 32'(bus.rx_stamp), 0);
`endif
    check("hex_router", 32'(bus.hex_router), 32'(m_hex_r));
    check("hex_data", 32'(bus.hex_data), 32'(m_hex_d));
  endtask

  task automatic tick();
    apply();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic zero_inputs();
    foreach (v_in[i]) begin v_in[i] = 0; p_in[i] = '0; end
    clr = 0; key = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic press();
    key = 1; tick();
    key = 0; tick();
  endtask

  int pool [12] = '{0, 1, 2, 5, 7, 9, 40, 63, 64, 100, 119, 120};

  initial begin
    zero_inputs();
    do_reset();
    check("reset_valid", 32'(bus.rx_valid), 0);
    check("reset_hex_router", 32'(bus.hex_router), 32'(DASH));
    check("reset_hex_data", 32'(bus.hex_data), 32'(DASH));

    // Single arrival: latency and hex decode
    v_in[5] = 1; p_in[5] = 14'h0123;
    tick();
    check("lat_early_valid", 32'(bus.rx_valid), 0);
    tick();
    check("s5_valid", 32'(bus.rx_valid), 1);
    check("s5_router", 32'(bus.rx_router), 5);
    check("s5_data", 32'(bus.rx_data), 32'h0123);
    check("s5_count", 32'(bus.rx_count), 1);
    tick();
    check("s5_hex_router", 32'(bus.hex_router), 32'(7'b0010010));
    check("s5_hex_data", 32'(bus.hex_data), 32'(7'b0110000));

    // Simultaneous arrivals drain lowest index first
    do_reset();
    v_in[2] = 1; v_in[7] = 1; v_in[120] = 1;
    p_in[2] = 14'h0a02; p_in[7] = 14'h0b07; p_in[120] = 14'h0c78;
    repeat (4) tick();
    check("multi_count", 32'(bus.rx_count), 3);
    check("multi_head0", 32'(bus.rx_router), 2);
    press();
    check("multi_head1", 32'(bus.rx_router), 7);
    press();
    check("multi_head2", 32'(bus.rx_router), 120);

    // Full FIFO holds pending slots
    do_reset();
    for (int i = 10; i < 16; i++) begin v_in[i] = 1; p_in[i] = 14'(i * 3); end
    repeat (7) tick();
    check("full_count", 32'(bus.rx_count), 4);
    check("full_head", 32'(bus.rx_router), 10);
    key = 1; tick();
    check("full_after_pop", 32'(bus.rx_count), 4);
    key = 0; tick();
    check("full_refill", 32'(bus.rx_count), 5);
    check("full_head2", 32'(bus.rx_router), 11);

    // Held key pops once
    do_reset();
    v_in[30] = 1; v_in[31] = 1; v_in[32] = 1;
    repeat (4) tick();
    key = 1;
    repeat (10) tick();
    key = 0;
    check("held_valid", 32'(bus.rx_valid), 1);
    check("held_head", 32'(bus.rx_router), 31);

    // Clear with held valid, then reset re-arrival
    do_reset();
    v_in[9] = 1; p_in[9] = 14'h0999;
    repeat (3) tick();
    clr = 1; tick();
    clr = 0; repeat (3) tick();
    check("clr_valid", 32'(bus.rx_valid), 0);
    check("clr_count", 32'(bus.rx_count), 0);
    rst_n = 0; tick();
    rst_n = 1; tick(); tick();
    check("rst9_valid", 32'(bus.rx_valid), 1);
    check("rst9_router", 32'(bus.rx_router), 9);
    check("rst9_stamp", 32'(bus.rx_stamp), 0);
    repeat (3) tick();
    check("rst9_count", 32'(bus.rx_count), 1);

    // Randomized traffic on a small pool of slots
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      foreach (pool[j]) begin
        if ($urandom_range(5) == 0) v_in[pool[j]] = !v_in[pool[j]];
        if ($urandom_range(1) == 1) p_in[pool[j]] = 14'($urandom);
      end
      if ($urandom_range(2) == 0) key = !key;
      clr = ($urandom_range(99) == 0);
      rst_n = ($urandom_range(299) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/collect_data_121.md
COLLECT_DATA_121 -- requirements
Module: collect_data_121

Interface
REQ-001 Parameter N_ROUTERS, default 121: number of router local-output slots observed.
REQ-002 Parameter PKT_W, default 15: slot width; bit PKT_W-1 = valid, bits PKT_W-2:0 = payload.
REQ-003 Parameter FIFO_DEPTH, default 4: arrival FIFO entries (power of two).
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_routers  in  N_ROUTERS*PKT_W (1815)  router local outputs; slot k at bits [k*15+14:k*15].
REQ-007 sw_clear  in  1  level, synchronous clear of collected state.
REQ-008 key_next  in  1  level button; rising edge pops the displayed entry.
REQ-009 rx_valid  out  1  FIFO non-empty.
REQ-010 rx_router  out  7  slot index of FIFO head, 0..120.
REQ-011 rx_data  out  14  payload of FIFO head.
REQ-012 rx_count  out  8  total pushes, saturating.
REQ-013 rx_stamp  out  16  arrival cycle stamp of head (see Configuration).
REQ-014 hex_router  out  7  active-low 7-segment, low nibble of rx_router.
REQ-015 hex_data  out  7  active-low 7-segment, low nibble of rx_data.

Function
REQ-016 Arrival SHALL be detected per slot as valid bit high now AND low in the registered previous-valid vector (prev_v, 121 bits, updated every cycle).
REQ-017 Arrivals SHALL set bits in a 121-bit pending vector; repeat arrivals on an already-pending slot SHALL merge into that one bit.
REQ-018 Each cycle, if pending is non-zero and FIFO not full, the lowest-index pending slot SHALL be pushed as {index, current payload} and its pending bit cleared.
REQ-019 If a pending slot's valid bit is low at service time, its pending bit SHALL be cleared without a push.
REQ-020 FIFO full: pending bits SHALL be held (no loss, no overwrite) until space frees.
REQ-021 Latency: valid first sampled high at edge E on an idle block -> rx_valid=1 with that entry after edge E+1; hex_* reflect it after edge E+2.
REQ-022 key_next SHALL be edge-detected via a registered flag; a rising edge with rx_valid=1 pops the head; with rx_valid=0 it is ignored.
REQ-023 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-024 rx_count SHALL increment per push, saturating at 255.
REQ-025 Empty FIFO: rx_router=0, rx_data=0, rx_stamp=0; hex_router and hex_data SHALL show a dash (7'b0111111).
REQ-026 Hex decode SHALL cover 0-F, registered.
REQ-027 sw_clear=1 SHALL empty the FIFO and zero pending and rx_count; prev_v SHALL still update, so held valids do not re-arrive.

Reset
REQ-028 rst_n=0 at an edge SHALL zero prev_v, pending, FIFO pointers, rx_count, key flag and stamp counter; rx_* = 0, hex_* = dash.
REQ-029 Reset mid-operation SHALL discard all queued entries.
REQ-030 A slot already valid when reset releases SHALL count as an arrival on the first post-reset cycle.

Configuration
REQ-031 ARRIVAL_STAMP_EN defined: a 16-bit free-running cycle counter (wraps 65535->0) SHALL be stored with each push and presented on rx_stamp.
REQ-032 ARRIVAL_STAMP_EN undefined: no counter and no stamp storage; rx_stamp SHALL be tied to 0.

Verification
REQ-033 Slot 5 valid, payload 0x0123 -> one cycle later rx_valid=1, rx_router=5, rx_data=0x0123, rx_count=1; hex shows 5 and 3.
REQ-034 Slots 2, 7 and 120 rise in the same cycle -> pushes in order 2, 7, 120 over 3 consecutive cycles; rx_count=3.
REQ-035 6 distinct arrivals, no key_next -> FIFO holds 4 entries, 2 remain pending; one pop -> the next pending slot is pushed on the following cycle.
REQ-036 key_next held high for 10 cycles with 3 entries -> exactly one pop; rx_valid stays 1.
REQ-037 Slot 9 held valid, sw_clear pulsed, then rst_n pulsed -> no entry after clear; after reset, one arrival of slot 9; with ARRIVAL_STAMP_EN, rx_stamp=0.
